// File: rtl/seq_signed_comparator.sv
// rtl/seq_signed_comparator.sv - multi-cycle signed/unsigned magnitude comparator
//
// Scans the operands CHUNK bits per cycle, starting at the MSB. Each operation
// uses a start/busy/done handshake and returns a one-hot gt/eq/lt result.
// Optional build macro: CMP_EARLY_EXIT_EN. When it is defined, the scan stops
// in the cycle the result is decided. Without it, every compare takes NCHUNK
// RUN cycles.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      request, sampled only in IDLE
//   is_signed  1 = two's-complement compare, 0 = unsigned (latched with start)
//   a, b       WIDTH-bit operands (latched with start)
//   busy       high while the scan is running
//   done       one-cycle completion pulse
//   gt/eq/lt   one-hot result, held until the next completion

module seq_signed_comparator #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);
  localparam logic [IDXW-1:0] IDX_ONE  = IDXW'(1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             signed_q;
  logic [IDXW-1:0]  idx;
  logic             decided;
  logic             pend_gt;
  logic             pend_lt;

  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic             sign_hit;
  logic             nxt_gt;
  logic             nxt_lt;
  logic             dec_now;
  logic             run_exit;

  assign busy = (state == S_RUN);
  assign done = (state == S_DONE);

  always_comb begin
    a_chunk  = a_q[int'(idx)*CHUNK +: CHUNK];
    b_chunk  = b_q[int'(idx)*CHUNK +: CHUNK];
    // Opposite signs settle the order immediately. When the signs match,
    // two's-complement values sort the same as unsigned values, so the
    // chunk scan gives the right answer without further sign handling.
    sign_hit = signed_q && (idx == LAST_IDX) && (a_q[WIDTH-1] != b_q[WIDTH-1]);
    nxt_gt   = pend_gt;
    nxt_lt   = pend_lt;
    if (!decided) begin
      if (sign_hit) begin
        nxt_gt = b_q[WIDTH-1];
        nxt_lt = a_q[WIDTH-1];
      end else begin
        nxt_gt = (a_chunk > b_chunk);
        nxt_lt = (a_chunk < b_chunk);
      end
    end
    dec_now = decided || nxt_gt || nxt_lt;
`ifdef CMP_EARLY_EXIT_EN
    run_exit = (idx == '0) || dec_now;
`else
    run_exit = (idx == '0);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      signed_q <= 1'b0;
      idx      <= '0;
      decided  <= 1'b0;
      pend_gt  <= 1'b0;
      pend_lt  <= 1'b0;
      gt       <= 1'b0;
      eq       <= 1'b0;
      lt       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            a_q      <= a;
            b_q      <= b;
            signed_q <= is_signed;
            idx      <= LAST_IDX;
            decided  <= 1'b0;
            pend_gt  <= 1'b0;
            pend_lt  <= 1'b0;
            state    <= S_RUN;
          end
        end
        S_RUN: begin
          if (run_exit) begin
            gt    <= nxt_gt;
            lt    <= nxt_lt;
            eq    <= ~(nxt_gt | nxt_lt);
            state <= S_DONE;
          end else begin
            idx     <= idx - IDX_ONE;
            decided <= dec_now;
            pend_gt <= nxt_gt;
            pend_lt <= nxt_lt;
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_signed_comparator.sv
// tb/tb_seq_signed_comparator.sv - self-checking bench for seq_signed_comparator

module tb_seq_signed_comparator;

  logic clk = 1'b0;
  logic rst_n;

  logic        start, is_signed;
  logic [31:0] a, b;
  logic        busy, done, gt, eq, lt;

  logic        s_start, s_is_signed;
  logic [3:0]  s_a, s_b;
  logic        s_busy, s_done, s_gt, s_eq, s_lt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  seq_signed_comparator #(.WIDTH(32), .CHUNK(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .is_signed(is_signed),
    .a(a), .b(b), .busy(busy), .done(done), .gt(gt), .eq(eq), .lt(lt)
  );

  seq_signed_comparator #(.WIDTH(4), .CHUNK(1)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(s_start), .is_signed(s_is_signed),
    .a(s_a), .b(s_b), .busy(s_busy), .done(s_done), .gt(s_gt), .eq(s_eq), .lt(s_lt)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [2:0]  exp;    // {gt, eq, lt}
    int          lat_e;  // done cycle with early exit
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Runs one operation on the 32-bit instance. With poke set, a conflicting
  // request is driven mid-scan and again during the done pulse.
  task automatic big_op(input logic [31:0] va, input logic [31:0] vb, input logic vs,
                        input bit poke, output logic [2:0] res, output int lat,
                        output int busy_n, output int done_n, output logic busy_after);
    @(negedge clk);
    a = va; b = vb; is_signed = vs; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = '0; b = '0;
    lat = -1; busy_n = 0; done_n = 0; res = 3'b000; busy_after = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (busy) busy_n++;
      if (done) begin
        if (lat < 0) begin
          lat = c;
          res = {gt, eq, lt};
        end
        done_n++;
        if (poke) begin
          start = 1'b1; a = 32'h7; b = 32'h1; is_signed = 1'b0;
        end
      end else if (lat >= 0) begin
        busy_after = busy;
        start = 1'b0;
        break;
      end
      if (poke && c == 3) begin
        start = 1'b1; a = 32'h7; b = 32'h1; is_signed = 1'b0;
      end else if (poke && c == 4) begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  task automatic small_op(input logic [3:0] va, input logic [3:0] vb, input logic vs,
                          output logic [2:0] res, output bit timed_out);
    @(negedge clk);
    s_a = va; s_b = vb; s_is_signed = vs; s_start = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0;
    timed_out = 1'b1;
    res = 3'b000;
    for (int c = 1; c <= 20; c++) begin
      if (s_done) begin
        res = {s_gt, s_eq, s_lt};
        timed_out = 1'b0;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk);
  endtask

  function automatic logic [2:0] model4(input logic [3:0] x, input logic [3:0] y, input logic s);
    int xi, yi;
    xi = (s && x[3]) ? int'(x) - 16 : int'(x);
    yi = (s && y[3]) ? int'(y) - 16 : int'(y);
    return {xi > yi, xi == yi, xi < yi};
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [2:0] res;
    int         lat, busy_n, done_n, exp_lat, done_seen;
    logic       busy_after;
    bit         to;

    vecs[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 3'b001, 2};
    vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 3'b100, 2};
    vecs[2] = '{32'h1234_5678, 32'h1234_5678, 1'b1, 3'b010, 9};
    vecs[3] = '{32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 3'b100, 2};
    vecs[4] = '{32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 3'b001, 2};
    vecs[5] = '{32'hFFFF_FFF8, 32'hFFFF_FFFD, 1'b1, 3'b001, 9};
    vecs[6] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 3'b010, 9};
    vecs[7] = '{32'h0000_0100, 32'h0000_00FF, 1'b0, 3'b100, 7};
    vecs[8] = '{32'h7FFF_FFFF, 32'h7FFF_FFFE, 1'b1, 3'b100, 9};
    vecs[9] = '{32'h8000_0000, 32'h8000_0001, 1'b1, 3'b001, 9};

    rst_n = 1'b0;
    start = 1'b0; is_signed = 1'b0; a = '0; b = '0;
    s_start = 1'b0; s_is_signed = 1'b0; s_a = '0; s_b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {busy, done, gt, eq, lt}, 5'b0);
    chk("reset_outputs_w4", {s_busy, s_done, s_gt, s_eq, s_lt}, 5'b0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
`ifdef CMP_EARLY_EXIT_EN
      exp_lat = vecs[i].lat_e;
`else
      exp_lat = 9;
`endif
      big_op(vecs[i].a, vecs[i].b, vecs[i].s, 1'b0, res, lat, busy_n, done_n, busy_after);
      chk($sformatf("v%0d_result", i), res, vecs[i].exp);
      chk($sformatf("v%0d_latency", i), lat, exp_lat);
      chk($sformatf("v%0d_done_width", i), done_n, 1);
      chk($sformatf("v%0d_busy_cycles", i), busy_n, exp_lat - 1);
      chk($sformatf("v%0d_idle_after", i), busy_after, 1'b0);
    end

    // Requests during RUN and DONE must be ignored.
    big_op(32'hFFFF_FFF8, 32'hFFFF_FFFD, 1'b1, 1'b1, res, lat, busy_n, done_n, busy_after);
    chk("ignore_start_result", res, 3'b001);
    chk("ignore_start_latency", lat, 9);
    chk("ignore_start_done_width", done_n, 1);
    chk("ignore_start_no_restart", busy_after, 1'b0);
    @(posedge clk); #1;
    chk("ignore_start_result_held", {gt, eq, lt}, 3'b001);

    // Reset in the middle of a scan.
    @(negedge clk);
    a = 32'd5; b = 32'd3; is_signed = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("midreset_busy_before", busy, 1'b1);
    chk("midreset_stale_result", {gt, eq, lt}, 3'b001);
    rst_n = 1'b0;
    #1;
    chk("midreset_async_clear", {busy, done, gt, eq, lt}, 5'b0);
    done_seen = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (done) done_seen++;
    end
    chk("midreset_no_done", done_seen, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (done || busy) done_seen++;
    end
    chk("postreset_stays_idle", done_seen, 0);
    big_op(32'd3, 32'd5, 1'b0, 1'b0, res, lat, busy_n, done_n, busy_after);
    chk("postreset_result", res, 3'b001);
    chk("postreset_latency", lat, 9);

    // 4-bit instance, one bit per cycle.
    small_op(4'b1000, 4'b0111, 1'b1, res, to);
    chk("w4_signed_8_vs_7", {to, res}, 4'b0001);
    small_op(4'b1000, 4'b0111, 1'b0, res, to);
    chk("w4_unsigned_8_vs_7", {to, res}, 4'b0100);
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 256; i++) begin
        logic [3:0] x, y;
        x = 4'(i >> 4);
        y = 4'(i);
        small_op(x, y, s[0], res, to);
        chk($sformatf("w4_sweep_s%0d_%0h_%0h", s, x, y), {to, res}, {1'b0, model4(x, y, s[0])});
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seq_signed_comparator.md
Name: seq_signed_comparator

Overview:
Parametrised multi-cycle magnitude comparator for WIDTH-bit operands. Each operation selects signed or unsigned mode. The block scans operands CHUNK bits per cycle, MSB first, and returns one-hot gt/eq/lt. It sits beside the ALU/branch unit as a shared slow-path compare resource, using a start/busy/done handshake.

Parameters:
WIDTH, 32, operand width in bits; must be an integer multiple of CHUNK, and WIDTH >= 2.
CHUNK, 4, bits compared per RUN cycle; NCHUNK = WIDTH/CHUNK.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
start  input  1  request; sampled only in IDLE.
is_signed  input  1  1 = two's-complement compare, 0 = unsigned; latched with start.
a  input  WIDTH  operand A; latched with start.
b  input  WIDTH  operand B; latched with start.
busy  output  1  high while in RUN.
done  output  1  one-cycle pulse in the DONE state.
gt  output  1  A > B.
eq  output  1  A == B.
lt  output  1  A < B.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE; busy=0, done=0, gt=0, eq=0, lt=0.
  - Operand registers and chunk index are cleared.
  - Applies mid-operation; the in-flight compare is discarded with no done pulse.
- State machine: IDLE -> RUN -> DONE -> IDLE.
  - IDLE: start=1 latches a, b, is_signed; sets idx=NCHUNK-1, decided=0; next state RUN. start=0 stays in IDLE.
  - RUN: busy=1; start is ignored. Per cycle:
    - First RUN cycle, if is_signed=1 and a[WIDTH-1]!=b[WIDTH-1]: the result is decided. A negative gives lt, otherwise gt.
    - Otherwise, if not yet decided, compare chunk idx of A and B (bits idx*CHUNK+CHUNK-1 : idx*CHUNK) as unsigned. Same-sign two's-complement values order correctly unsigned. If the chunks differ, the result is decided (gt or lt per that chunk).
    - Once decided, the pending result is frozen; later chunks never override it.
    - Leave RUN after the idx=0 cycle (or earlier, see Optional Feature). If still undecided at exit, the result is eq.
  - DONE: done=1 for exactly one cycle; next state IDLE. start during DONE is ignored.
- Result registers gt/eq/lt:
  - Written only on the RUN->DONE transition; exactly one is high after any completed operation.
  - Held stable through IDLE and subsequent RUN until the next DONE. Stale values stay visible while busy=1.
- Latency (start-sampling edge = cycle 0): full scan gives done high in cycle NCHUNK+1.
- is_signed=0: the MSB is treated as magnitude, with no sign shortcut.
- Back-to-back throughput: one new operation per NCHUNK+2 cycles (full scan).

Optional Feature:
Macro CMP_EARLY_EXIT_EN.
- Defined: RUN transitions to DONE in the same cycle the result becomes decided.
  - Sign-differ case: done in cycle 2.
  - Difference found at chunk idx: done in cycle NCHUNK-idx+1.
  - Equal operands still take the full NCHUNK cycles.
- Undefined: RUN always runs all NCHUNK cycles; latency is a constant NCHUNK+1. Results are identical in both builds; only timing differs.

Test Plan:
1. Defaults; a=0xFFFFFFFF, b=0x00000001. is_signed=1 -> lt=1. is_signed=0 -> gt=1. Check the one-hot result and a single-cycle done.
2. a=b=0x12345678, signed -> eq=1. done in cycle 9 in both builds; busy high in cycles 1-8.
3. a=0x80000000, b=0x7FFFFFFF, is_signed=0 -> gt=1. Done in cycle 2 with CMP_EARLY_EXIT_EN, cycle 9 without. Same operands signed -> lt=1.
4. a=0xFFFFFFF8 (-8), b=0xFFFFFFFD (-3), signed -> lt=1; the difference is in chunk 0, so done in cycle 9 in both builds. Then pulse start with new operands while busy -> the new request is ignored, and the next result reflects only the first operands.
5. Start a=5, b=3. Assert rst_n=0 in cycle 3 -> busy, done, gt, eq and lt all 0 immediately, with no done pulse. After release, a fresh start of a=3, b=5 unsigned -> lt=1.
6. WIDTH=4, CHUNK=1: sweep all 256 (A,B) pairs in signed and unsigned modes against a golden model. Signed 4'b1000 vs 4'b0111 -> lt=1; unsigned -> gt=1.
